// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - sums NUM_INPUTS signed products plus a bias, saturates,
// optionally applies ReLU and hands one neuron result out on a valid/ready port.
module neuron_accumulator #(
  parameter int NUM_INPUTS = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] product_i,
  input  logic                  product_valid_i,
  output logic                  product_ready_o,
  input  logic [DATA_WIDTH-1:0] bias_i,
  input  logic                  relu_en_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  busy_o
);

  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);
  localparam int EXT_W = ACC_WIDTH - DATA_WIDTH;

  // Saturation bounds of the DATA_WIDTH result, expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(EXT_W + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(EXT_W + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_ADD_BIAS = 2'd1,
    ST_ACTIVATE = 2'd2,
    ST_OUT      = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic        [CNT_W-1:0]        count_q, count_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic        [DATA_WIDTH-1:0]   bias_q, bias_d;
  logic                           relu_q, relu_d;
  logic        [DATA_WIDTH-1:0]   result_q, result_d;
  logic                           result_valid_q, result_valid_d;

  logic signed [ACC_WIDTH-1:0]    product_ext;
  logic signed [ACC_WIDTH-1:0]    bias_ext;
  logic        [DATA_WIDTH-1:0]   sat_value;

  assign product_ext = {{EXT_W{product_i[DATA_WIDTH-1]}}, product_i};
  assign bias_ext    = {{EXT_W{bias_q[DATA_WIDTH-1]}}, bias_q};

  always_comb begin
    sat_value = acc_q[DATA_WIDTH-1:0];
    if (acc_q > SAT_MAX) begin
      sat_value = SAT_MAX[DATA_WIDTH-1:0];
    end else if (acc_q < SAT_MIN) begin
      sat_value = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    acc_d          = acc_q;
    bias_d         = bias_q;
    relu_d         = relu_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    case (state_q)
      ST_ACCUM: begin
        if (product_valid_i) begin
          // The first beat of a neuron starts a fresh sum and captures its bias/ReLU.
          if (count_q == '0) begin
            acc_d  = product_ext;
            bias_d = bias_i;
            relu_d = relu_en_i;
          end else begin
            acc_d = acc_q + product_ext;
          end
          if (count_q == LAST_CNT) begin
            count_d = '0;
            state_d = ST_ADD_BIAS;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_ADD_BIAS: begin
        acc_d   = acc_q + bias_ext;
        state_d = ST_ACTIVATE;
      end
      ST_ACTIVATE: begin
        result_d       = (relu_q && sat_value[DATA_WIDTH-1]) ? '0 : sat_value;
        result_valid_d = 1'b1;
        state_d        = ST_OUT;
      end
      ST_OUT: begin
        if (result_ready_i) begin
          result_valid_d = 1'b0;
          state_d        = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_ACCUM;
      count_q        <= '0;
      acc_q          <= '0;
      bias_q         <= '0;
      relu_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      acc_q          <= acc_d;
      bias_q         <= bias_d;
      relu_q         <= relu_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign product_ready_o = (state_q == ST_ACCUM) && !reset_i;
  assign busy_o          = (count_q != '0) || (state_q != ST_ACCUM);
  assign result_o        = result_q;
  assign result_valid_o  = result_valid_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - directed and randomized checks of neuron_accumulator
// against an arithmetic reference model.
module tb_neuron_accumulator;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [DW-1:0] product_i;
  logic          product_valid_i;
  logic          product_ready_o;
  logic [DW-1:0] bias_i;
  logic          relu_en_i;
  logic [DW-1:0] result_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          busy_o;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] pv [N];

  neuron_accumulator #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .ACC_WIDTH(48)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .product_i       (product_i),
    .product_valid_i (product_valid_i),
    .product_ready_o (product_ready_o),
    .bias_i          (bias_i),
    .relu_en_i       (relu_en_i),
    .result_o        (result_o),
    .result_valid_o  (result_valid_o),
    .result_ready_i  (result_ready_i),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] bias, input bit relu);
    longint sum;
    int     si;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      si = pv[i];
      sum += si;
    end
    si = bias;
    sum += si;
    if (sum > 64'sd2147483647) sum = 64'sd2147483647;
    if (sum < -64'sd2147483648) sum = -64'sd2147483648;
    if (relu && sum < 0) sum = 0;
    return sum[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Feeds pv[] as one neuron; gap<0 picks a random 0..3 bubble before each beat.
  task automatic drive_neuron(input logic [DW-1:0] bias, input bit relu, input int gap,
                              input bit scramble);
    int g;
    int w;
    for (int i = 0; i < N; i++) begin
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      product_valid_i = 1'b0;
      repeat (g) tick();
      product_valid_i = 1'b1;
      product_i = pv[i];
      if (i == 0) begin
        bias_i = bias;
        relu_en_i = relu;
      end else if (scramble) begin
        bias_i = $urandom;
        relu_en_i = ~relu;
      end
      w = 0;
      while (!product_ready_o && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) check("ready_timeout", 64'(product_ready_o), 64'd1);
      tick();
      if (i == 0) check("busy_after_first", 64'(busy_o), 64'd1);
    end
    product_valid_i = 1'b0;
    product_i = $urandom;
    check("valid_E0", 64'(result_valid_o), 64'd0);
    tick();
    check("valid_E0p1", 64'(result_valid_o), 64'd0);
    tick();
    check("valid_E0p2", 64'(result_valid_o), 64'd1);
    check("result", 64'(result_o), 64'(ref_result(bias, relu)));
  endtask

  task automatic take_result(input int stall, input bit valid_during);
    logic [DW-1:0] held;
    held = result_o;
    result_ready_i = 1'b0;
    product_valid_i = valid_during;
    repeat (stall) begin
      tick();
      check("stall_result_stable", 64'(result_o), 64'(held));
      check("stall_valid", 64'(result_valid_o), 64'd1);
      check("stall_ready_low", 64'(product_ready_o), 64'd0);
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    product_valid_i = 1'b0;
    check("post_hs_valid", 64'(result_valid_o), 64'd0);
    check("post_hs_ready", 64'(product_ready_o), 64'd1);
    check("post_hs_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(result_valid_o), 64'd0);
    check({tag, "_result"}, 64'(result_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_ready_in_reset"}, 64'(product_ready_o), 64'd0);
  endtask

  initial begin
    reset_i = 1'b1;
    product_i = '0;
    product_valid_i = 1'b0;
    bias_i = '0;
    relu_en_i = 1'b0;
    result_ready_i = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check_reset_state("reset");
    reset_i = 1'b0;
    #1;
    check("ready_after_reset", 64'(product_ready_o), 64'd1);
    @(negedge clk);

    // Basic sum
    pv[0] = 32'h0001_0000; pv[1] = 32'h0002_0000; pv[2] = 32'h0003_0000; pv[3] = 32'h0004_0000;
    drive_neuron(32'h0001_0000, 1'b0, 0, 1'b0);
    check("basic_const", 64'(result_o), 64'h000B_0000);
    take_result(0, 1'b0);

    // Sign and ReLU
    for (int i = 0; i < N; i++) pv[i] = 32'hFFFF_0000;
    drive_neuron(32'h0, 1'b0, 0, 1'b0);
    check("neg_const", 64'(result_o), 64'hFFFC_0000);
    take_result(0, 1'b0);
    drive_neuron(32'h0, 1'b1, 0, 1'b0);
    check("relu_const", 64'(result_o), 64'h0);
    take_result(0, 1'b0);

    // Saturation both ways
    for (int i = 0; i < N; i++) pv[i] = 32'h7FFF_FFFF;
    drive_neuron(32'h7FFF_FFFF, 1'b0, 0, 1'b0);
    check("sat_pos_const", 64'(result_o), 64'h7FFF_FFFF);
    take_result(0, 1'b0);
    for (int i = 0; i < N; i++) pv[i] = 32'h8000_0000;
    drive_neuron(32'h8000_0000, 1'b0, 0, 1'b0);
    check("sat_neg_const", 64'(result_o), 64'h8000_0000);
    take_result(0, 1'b0);

    // Bubbles, then backpressure with valid held high, then second neuron
    pv[0] = 32'h0001_0000; pv[1] = 32'h0002_0000; pv[2] = 32'h0003_0000; pv[3] = 32'h0004_0000;
    drive_neuron(32'h0001_0000, 1'b0, 3, 1'b0);
    check("bubble_const", 64'(result_o), 64'h000B_0000);
    product_i = 32'h0001_0000;
    take_result(5, 1'b1);
    for (int i = 0; i < N; i++) pv[i] = 32'h0001_0000;
    drive_neuron(32'h0, 1'b0, 0, 1'b0);
    check("second_const", 64'(result_o), 64'h0004_0000);
    take_result(0, 1'b0);

    // Reset after two accepted beats
    product_valid_i = 1'b1;
    product_i = 32'h0100_0000;
    bias_i = 32'h0100_0000;
    relu_en_i = 1'b1;
    tick();
    tick();
    product_valid_i = 1'b0;
    reset_i = 1'b1;
    tick();
    check_reset_state("midreset");
    reset_i = 1'b0;
    #1;
    check("midreset_ready", 64'(product_ready_o), 64'd1);
    @(negedge clk);
    drive_neuron(32'h0, 1'b0, 0, 1'b0);
    check("after_reset_const", 64'(result_o), 64'h0004_0000);

    // Reset while in OUT
    reset_i = 1'b1;
    tick();
    check_reset_state("outreset");
    reset_i = 1'b0;
    @(negedge clk);

    // First-beat sampling of bias/ReLU
    pv[0] = 32'hFFF0_0000; pv[1] = 32'h0000_1000; pv[2] = 32'h0000_2000; pv[3] = 32'h0000_3000;
    drive_neuron(32'h0000_0100, 1'b1, 1, 1'b1);
    check("sample_const", 64'(result_o), 64'h0);
    take_result(1, 1'b0);

    // Randomized neurons
    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] b;
      bit            r;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: pv[i] = 32'h7FFF_FFFF - $urandom_range(0, 255);
          1: pv[i] = 32'h8000_0000 + $urandom_range(0, 255);
          default: pv[i] = $urandom;
        endcase
      end
      b = $urandom;
      r = 1'($urandom_range(0, 1));
      drive_neuron(b, r, -1, 1'($urandom_range(0, 1)));
      take_result($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Downstream consumer of the `multiplier` stage in the neural-network datapath. It accepts a stream of signed 32-bit weight×input products, sums `NUM_INPUTS` of them into one neuron pre-activation, and adds a per-neuron bias. It then saturates the sum to 32 bits, optionally applies ReLU, and presents the single neuron result on a valid/ready output. One neuron is processed at a time; the input stall is the only backpressure path back to the multiplier.

## Interface
Parameters:
- `NUM_INPUTS`, 16: products summed per neuron; must be ≥ 1.
- `DATA_WIDTH`, 32: width of products, bias and result; signed two's complement, same fixed-point format throughout.
- `ACC_WIDTH`, 48: internal accumulator width; must be ≥ `DATA_WIDTH + $clog2(NUM_INPUTS) + 1`, so the accumulation never wraps.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `reset_i` in 1: reset, synchronous and active-high.
- `product_i` in `DATA_WIDTH`: signed product from the multiplier.
- `product_valid_i` in 1: `product_i` is valid this cycle.
- `product_ready_o` out 1: block accepts a product this cycle.
- `bias_i` in `DATA_WIDTH`: signed neuron bias, sampled with the first product of a neuron.
- `relu_en_i` in 1: enable ReLU, sampled with the first product of a neuron.
- `result_o` out `DATA_WIDTH`: signed neuron result.
- `result_valid_o` out 1: `result_o` is valid.
- `result_ready_i` in 1: downstream accepts the result.
- `busy_o` out 1: a neuron is in progress (at least one product accepted, result not yet handed off).

## Operation
- A beat is accepted on a rising edge when `product_valid_i && product_ready_o`.
- FSM states and transitions:
  - ACCUM:
    - `product_ready_o`=1.
    - Each accepted beat adds sign-extended `product_i` to `acc` and increments `count` (0..`NUM_INPUTS`-1).
    - On the beat with `count`==0, `acc` is loaded with the product, not added to it. `bias_i` and `relu_en_i` are latched on that same beat.
    - The beat with `count`==`NUM_INPUTS`-1 moves the FSM to ADD_BIAS and resets `count` to 0.
  - ADD_BIAS: `acc <= acc + sext(bias)`; unconditional move to ACTIVATE.
  - ACTIVATE:
    - `result_o` gets the saturated `acc`: values > 2^(DATA_WIDTH-1)-1 become 0x7FFFFFFF, values < -2^(DATA_WIDTH-1) become 0x80000000.
    - If ReLU is latched on and the saturated value is negative, `result_o` is 0 instead.
    - Move to OUT.
  - OUT:
    - `result_valid_o`=1 and `product_ready_o`=0.
    - `result_valid_o` and `result_o` hold stable until `result_ready_i`=1; then the FSM moves to ACCUM.
- Gaps in `product_valid_i` are allowed at any point in ACCUM. `acc` and `count` hold during gaps.
- In ADD_BIAS, ACTIVATE and OUT, `product_valid_i` is ignored and no products are consumed.
- `NUM_INPUTS`=1: the single beat goes straight to ADD_BIAS.
- `busy_o` = (`count` != 0) || (state != ACCUM).

## Timing
- Reset values:
  - State ACCUM, `count`=0, `acc`=0, `result_o`=0, `result_valid_o`=0, `busy_o`=0.
  - `product_ready_o` is forced 0 while `reset_i`=1 and is 1 on the first cycle after reset is released.
- Reset mid-operation, in any state: on the reset edge all partial `acc`, `count`, latched bias/ReLU and any pending result are discarded. No stale data reaches the next neuron.
- Latency: with the last product accepted on edge E0, the FSM enters ADD_BIAS after E0 and ACTIVATE after E0+1. `result_valid_o`=1 after E0+2.
- Handshake on edge Eh (valid && ready in OUT): `result_valid_o`=0 after Eh and `product_ready_o`=1 in the same cycle. The next neuron's first product can be accepted on Eh+1.
- Minimum neuron period with no stalls: `NUM_INPUTS`+3 cycles.
- `product_ready_o` and `busy_o` are decoded from registered state only; they have no combinational path from `product_valid_i`.
- `result_o` changes only on entry to OUT (from ACTIVATE) and on reset.

## Test plan
All values are Q16.16 with `NUM_INPUTS`=4.
- Basic sum: products 0x00010000, 0x00020000, 0x00030000, 0x00040000 back-to-back; bias 0x00010000; ReLU off → `result_o`=0x000B0000. `result_valid_o` is high exactly 2 edges after the 4th accept.
- Sign/ReLU: four products 0xFFFF0000, bias 0 → 0xFFFC0000 with ReLU off. Repeating with ReLU on → 0x00000000.
- Saturation:
  - Four products 0x7FFFFFFF plus bias 0x7FFFFFFF → 0x7FFFFFFF.
  - Four products 0x80000000 plus bias 0x80000000 → 0x80000000.
- Bubbles and backpressure:
  - Insert 3-cycle gaps between products → same result as the Basic sum case.
  - Hold `result_ready_i`=0 for 5 cycles with `product_valid_i`=1 throughout → `result_o` stays stable, `product_ready_o`=0, no products consumed.
  - Release `result_ready_i` → a second neuron (four 0x00010000 products, bias 0) yields 0x00040000.
- Reset mid-operation:
  - Assert `reset_i` after 2 accepted products → all outputs return to reset values.
  - A fresh set of four 0x00010000 products with bias 0 then yields 0x00040000.
  - Also assert reset while in OUT → `result_valid_o` drops on the reset edge.
- `bias_i`/`relu_en_i` sampling: change both inputs after the first beat → the values latched on the first beat are used.
